usb_device: RTL and testbench
=============================

// Module: usb_device
// PURPOSE
//  Minimal USB full-speed-style receive front end: samples the D+/D- pair, decodes line
//  state, detects SYNC, NRZI-decodes, removes stuffed bits and assembles bytes LSB-first.
//  Each completed byte appears on data_out with a one-cycle usb_en strobe for downstream
//  packet logic. Receive only; no transmit, CRC or PID checking.
// PARAMETERS
//  CLKS_PER_BIT  1  clk cycles per USB bit time; legal values are >=1.
//  SYNC_MIN_ZEROS  3  minimum decoded 0 bits required before the closing 1 of SYNC.
// PORTS
//  clk       in   1  single system clock, rising-edge.
//  rst       in   1  asynchronous, active-high reset.
//  usb_dp    in   1  D+ line, asynchronous to clk.
//  usb_dm    in   1  D- line, asynchronous to clk.
//  usb_en    out  1  byte-valid strobe, high for exactly one clk per received byte.
//  data_out  out  8  last received byte, held until the next byte completes.
// BEHAVIOUR
//  Reset
//  - On rst: data_out=8'h00, usb_en=0, FSM=IDLE, counters=0.
//  - Synchronizer and previous-line-state registers reset to J (dp=1, dm=0).
//  Input path
//  - dp and dm each pass through a 2-flop synchronizer.
//  - Line state decode: J=10, K=01, SE0=00, SE1=11 (illegal).
//  Bit timing
//  - Phase counter restarts on every synced line-state change.
//  - Bit sample taken when counter==CLKS_PER_BIT/2, then every CLKS_PER_BIT clks.
//  - With CLKS_PER_BIT=1, every clk is a bit sample.
//  NRZI decode
//  - Bit=1 if the sampled state equals the previous J/K sample; bit=0 if it differs.
//  FSM states: IDLE, SYNC, DATA, EOP
//  - IDLE: J and SE0 ignored. K -> SYNC with zero_cnt=1. SE1 ignored.
//  - SYNC, bit 0: zero_cnt++.
//  - SYNC, bit 1: if zero_cnt>=SYNC_MIN_ZEROS -> DATA (bit_cnt=0, ones_cnt=0), else -> IDLE.
//  - SYNC, SE0 or SE1: -> IDLE.
//  - DATA: decoded bit shifts in at MSB, shift-right (LSB first).
//  - DATA: bit_cnt wraps 7->0. On the 8th bit, the next clk sets data_out=shift value and usb_en=1 for 1 clk.
//  - DATA, bit stuffing: ones_cnt counts consecutive 1s. After 6 ones, the next bit is discarded.
//    If it is 0, ones_cnt=0. If it is 1, stuff error -> IDLE; the partial byte is dropped and no strobe is made.
//  - DATA: SE0 -> EOP; any partial byte (bit_cnt!=0) is discarded silently.
//  - DATA: SE1 -> IDLE (abort), no strobe.
//  - EOP: stay while SE0. J -> IDLE. K or SE1 -> IDLE.
//  Output rules
//  - usb_en is never high two consecutive clks when CLKS_PER_BIT=1 unless bytes complete back-to-back (impossible: 8 bits min).
//  - data_out changes only together with a usb_en pulse.
//  Boundary conditions
//  - Reset asserted mid-packet: immediate return to reset values; no strobe.
//  - Simultaneous events: stuffed-bit discard has priority over byte completion; a stuffed bit never counts toward bit_cnt.
// TESTING  (CLKS_PER_BIT=1, patterns given per clk in synced line states)
//  1 Reset, then hold SE0 20 clks, then J 20 clks -> usb_en stays 0, data_out=8'h00.
//  2 J, SYNC K J K J K J K K, NRZI of 8'hA5, SE0 SE0 J -> one usb_en pulse, data_out=8'hA5, FSM back to IDLE.
//  3 SYNC + 8'hFF + stuffed 0 + 8'h01 + EOP -> two pulses, data_out 8'hFF then 8'h01.
//  4 SYNC + seven consecutive 1 bits -> stuff error, no pulse, data_out unchanged, IDLE.
//  5 SYNC + 4 data bits + SE1 -> abort, no pulse; a following valid packet of 8'h3C is received correctly.
//  6 Isolated dp or dm pulses, alternating 10/01 without KK close, 11 pulses -> usb_en never asserts.
//  7 rst pulse during DATA after 5 bits -> outputs 0 immediately; the next packet decodes normally.

Source files
------------

// File: rtl/usb_device.sv
// usb_device: receive-only USB full-speed-style front end.
//   Synchronises D+/D-, decodes line state, recovers bit timing, detects SYNC,
//   NRZI-decodes, strips stuffed bits and assembles bytes LSB-first.
// Ports:
//   clk      - system clock, rising edge
//   rst      - asynchronous active-high reset
//   usb_dp   - D+ line (asynchronous to clk)
//   usb_dm   - D- line (asynchronous to clk)
//   usb_en   - one-clk strobe per completed byte
//   data_out - last completed byte, held until the next one
module usb_device #(
    parameter int unsigned CLKS_PER_BIT   = 1,
    parameter int unsigned SYNC_MIN_ZEROS = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       usb_dp,
    input  logic       usb_dm,
    output logic       usb_en,
    output logic [7:0] data_out
);

    localparam int unsigned PW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned ZW = (SYNC_MIN_ZEROS > 0) ? $clog2(SYNC_MIN_ZEROS + 1) : 1;
    localparam logic [PW-1:0] HalfBit   = PW'(CLKS_PER_BIT / 2);
    localparam logic [PW-1:0] LastPhase = PW'(CLKS_PER_BIT - 1);
    localparam logic [ZW-1:0] ZeroMin   = ZW'(SYNC_MIN_ZEROS);

    localparam logic [1:0] LsJ   = 2'b10;
    localparam logic [1:0] LsK   = 2'b01;
    localparam logic [1:0] LsSe0 = 2'b00;
    localparam logic [1:0] LsSe1 = 2'b11;

    typedef enum logic [1:0] {StIdle, StSync, StData, StEop} state_e;

    logic          dp_meta_q, dp_sync_q, dm_meta_q, dm_sync_q;
    logic [1:0]    prev_ls_q;
    logic [PW-1:0] phase_q, phase_d;
    logic [1:0]    last_jk_q, last_jk_d;
    state_e        state_q, state_d;
    logic [ZW-1:0] zero_cnt_q, zero_cnt_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [2:0]    ones_cnt_q, ones_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    data_out_q, data_out_d;
    logic          usb_en_q, usb_en_d;

    logic [1:0] ls;
    logic       sample;
    logic       is_jk;
    logic       nrzi_bit;

    assign ls       = {dp_sync_q, dm_sync_q};
    assign is_jk    = (ls == LsJ) || (ls == LsK);
    assign nrzi_bit = (ls == last_jk_q);
    assign usb_en   = usb_en_q;
    assign data_out = data_out_q;

    // Phase restarts on any line change so the sample point re-centres on every edge.
    always_comb begin
        if (ls != prev_ls_q) begin
            phase_d = '0;
        end else if (phase_q == LastPhase) begin
            phase_d = '0;
        end else begin
            phase_d = phase_q + 1'b1;
        end
        sample = (phase_d == HalfBit);
    end

    always_comb begin
        state_d    = state_q;
        last_jk_d  = last_jk_q;
        zero_cnt_d = zero_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        ones_cnt_d = ones_cnt_q;
        shift_d    = shift_q;
        data_out_d = data_out_q;
        usb_en_d   = 1'b0;

        if (sample) begin
            if (is_jk) begin
                last_jk_d = ls;
            end
            case (state_q)
                StIdle: begin
                    if (ls == LsK) begin
                        state_d    = StSync;
                        zero_cnt_d = ZW'(1);
                    end
                end
                StSync: begin
                    if (!is_jk) begin
                        state_d = StIdle;
                    end else if (!nrzi_bit) begin
                        // Saturate: only reaching the minimum matters.
                        if (zero_cnt_q < ZeroMin) begin
                            zero_cnt_d = zero_cnt_q + 1'b1;
                        end
                    end else if (zero_cnt_q >= ZeroMin) begin
                        state_d    = StData;
                        bit_cnt_d  = 3'd0;
                        ones_cnt_d = 3'd0;
                    end else begin
                        state_d = StIdle;
                    end
                end
                StData: begin
                    if (ls == LsSe0) begin
                        state_d = StEop;
                    end else if (ls == LsSe1) begin
                        state_d = StIdle;
                    end else if (ones_cnt_q == 3'd6) begin
                        // Stuffed bit: never shifted, never counted.
                        if (nrzi_bit) begin
                            state_d = StIdle;
                        end else begin
                            ones_cnt_d = 3'd0;
                        end
                    end else begin
                        shift_d    = {nrzi_bit, shift_q[7:1]};
                        ones_cnt_d = nrzi_bit ? ones_cnt_q + 3'd1 : 3'd0;
                        bit_cnt_d  = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            usb_en_d   = 1'b1;
                            data_out_d = {nrzi_bit, shift_q[7:1]};
                        end
                    end
                end
                StEop: begin
                    if (ls != LsSe0) begin
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dp_meta_q  <= 1'b1;
            dp_sync_q  <= 1'b1;
            dm_meta_q  <= 1'b0;
            dm_sync_q  <= 1'b0;
            prev_ls_q  <= LsJ;
            phase_q    <= '0;
            last_jk_q  <= LsJ;
            state_q    <= StIdle;
            zero_cnt_q <= '0;
            bit_cnt_q  <= 3'd0;
            ones_cnt_q <= 3'd0;
            shift_q    <= 8'h00;
            data_out_q <= 8'h00;
            usb_en_q   <= 1'b0;
        end else begin
            dp_meta_q  <= usb_dp;
            dp_sync_q  <= dp_meta_q;
            dm_meta_q  <= usb_dm;
            dm_sync_q  <= dm_meta_q;
            prev_ls_q  <= ls;
            phase_q    <= phase_d;
            last_jk_q  <= last_jk_d;
            state_q    <= state_d;
            zero_cnt_q <= zero_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            ones_cnt_q <= ones_cnt_d;
            shift_q    <= shift_d;
            data_out_q <= data_out_d;
            usb_en_q   <= usb_en_d;
        end
    end

endmodule

// File: tb/tb_usb_device.sv
// tb_usb_device: directed bench for usb_device with CLKS_PER_BIT=1.
//   Packets are built by a small NRZI/bit-stuffing encoder; a negedge monitor
//   collects every strobed byte and watches for double strobes and for data_out
//   moving without a strobe.
module tb_usb_device;

    localparam logic [1:0] LsJ   = 2'b10;
    localparam logic [1:0] LsK   = 2'b01;
    localparam logic [1:0] LsSe0 = 2'b00;
    localparam logic [1:0] LsSe1 = 2'b11;

    logic       clk = 1'b0;
    logic       rst;
    logic       usb_dp;
    logic       usb_dm;
    logic       usb_en;
    logic [7:0] data_out;

    int         n_checks = 0;
    int         n_bad    = 0;
    int         n_double = 0;
    int         n_glitch = 0;
    logic       en_prev   = 1'b0;
    logic [7:0] data_prev = 8'h00;
    logic [7:0] rx_q[$];

    logic enc_k;     // 1 when the encoder's current line state is K
    int   enc_ones;

    always #5 clk = ~clk;

    usb_device #(
        .CLKS_PER_BIT  (1),
        .SYNC_MIN_ZEROS(3)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .usb_dp  (usb_dp),
        .usb_dm  (usb_dm),
        .usb_en  (usb_en),
        .data_out(data_out)
    );

    always @(negedge clk) begin
        if (rst) begin
            en_prev   = 1'b0;
            data_prev = 8'h00;
        end else begin
            if (usb_en) rx_q.push_back(data_out);
            if (usb_en && en_prev) n_double++;
            if (!usb_en && (data_out !== data_prev)) n_glitch++;
            en_prev   = usb_en;
            data_prev = data_out;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rx_at(input int i);
        return (i < rx_q.size()) ? {24'h0, rx_q[i]} : 32'hffff_ffff;
    endfunction

    task automatic drive(input logic [1:0] ls);
        {usb_dp, usb_dm} = ls;
        @(negedge clk);
    endtask

    task automatic idle_j(input int n);
        repeat (n) drive(LsJ);
    endtask

    task automatic send_sync();
        for (int i = 0; i < 7; i++) drive((i % 2 == 0) ? LsK : LsJ);
        drive(LsK);
        enc_k    = 1'b1;
        enc_ones = 0;
    endtask

    task automatic send_raw_bit(input logic b);
        if (!b) enc_k = ~enc_k;
        drive(enc_k ? LsK : LsJ);
    endtask

    task automatic send_bit(input logic b);
        send_raw_bit(b);
        if (b) begin
            enc_ones++;
            if (enc_ones == 6) begin
                send_raw_bit(1'b0);
                enc_ones = 0;
            end
        end else begin
            enc_ones = 0;
        end
    endtask

    task automatic send_byte(input logic [7:0] d);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
    endtask

    task automatic send_eop();
        drive(LsSe0);
        drive(LsSe0);
        idle_j(6);
    endtask

    initial begin
        logic [7:0] part;
        rst = 1'b1;
        {usb_dp, usb_dm} = LsJ;
        enc_k    = 1'b0;
        enc_ones = 0;
        repeat (2) @(negedge clk);
        check_eq("rst_en", {31'h0, usb_en}, 32'h0);
        check_eq("rst_data", {24'h0, data_out}, 32'h0);
        rst = 1'b0;

        // 1: SE0 then J idle, nothing decoded
        repeat (20) drive(LsSe0);
        idle_j(20);
        check_eq("t1_pulses", rx_q.size(), 0);
        check_eq("t1_data", {24'h0, data_out}, 32'h0);

        // 2: single byte A5
        idle_j(2);
        send_sync();
        send_byte(8'hA5);
        send_eop();
        check_eq("t2_pulses", rx_q.size(), 1);
        check_eq("t2_byte", rx_at(0), 32'hA5);
        check_eq("t2_data", {24'h0, data_out}, 32'hA5);
        rx_q.delete();

        // 3: FF needs a stuffed zero, then 01
        send_sync();
        send_byte(8'hFF);
        send_byte(8'h01);
        send_eop();
        check_eq("t3_pulses", rx_q.size(), 2);
        check_eq("t3_byte0", rx_at(0), 32'hFF);
        check_eq("t3_byte1", rx_at(1), 32'h01);
        rx_q.delete();

        // 4: seven ones is a stuff error
        send_sync();
        repeat (7) send_raw_bit(1'b1);
        send_eop();
        check_eq("t4_pulses", rx_q.size(), 0);
        check_eq("t4_data", {24'h0, data_out}, 32'h01);

        // 5: SE1 abort mid-byte, then a clean 3C
        send_sync();
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        drive(LsSe1);
        idle_j(4);
        send_sync();
        send_byte(8'h3C);
        send_eop();
        check_eq("t5_pulses", rx_q.size(), 1);
        check_eq("t5_byte", rx_at(0), 32'h3C);
        rx_q.delete();

        // 6: glitches and an unterminated SYNC
        idle_j(5);
        drive(LsK);
        idle_j(5);
        drive(LsSe1);
        drive(LsSe0);
        idle_j(3);
        for (int i = 0; i < 8; i++) drive((i % 2 == 0) ? LsK : LsJ);
        drive(LsSe1);
        idle_j(10);
        check_eq("t6_pulses", rx_q.size(), 0);
        check_eq("t6_data", {24'h0, data_out}, 32'h3C);

        // 7: reset after five data bits, then a normal packet
        send_sync();
        part = 8'h96;
        for (int i = 0; i < 5; i++) send_bit(part[i]);
        rst = 1'b1;
        #1;
        check_eq("t7_rst_data", {24'h0, data_out}, 32'h0);
        check_eq("t7_rst_en", {31'h0, usb_en}, 32'h0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        idle_j(4);
        check_eq("t7_pulses_rst", rx_q.size(), 0);
        send_sync();
        send_byte(8'hC3);
        send_eop();
        check_eq("t7_pulses", rx_q.size(), 1);
        check_eq("t7_byte", rx_at(0), 32'hC3);
        check_eq("t7_data", {24'h0, data_out}, 32'hC3);

        check_eq("double_strobe", n_double, 0);
        check_eq("data_no_strobe", n_glitch, 0);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
